mem_responder: RTL and testbench

Memory-side responder for a valid/ready load/store request interface. It services one outstanding word request at a time from a 2^ADDR_WIDTH × 32-bit storage array. A configurable number of wait states is inserted before each access. It is the slave end of the data path a multi-cycle core issues load/store requests on, replacing a zero-latency combinational memory.

---
 rtl/mem_responder.sv | 154 +++++++++++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding valid/ready word memory with WAIT_CYCLES wait states per access.
// Define WRITE_ACK_EN to make writes produce a resp_valid acknowledge pulse like reads do.
module mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("mem_responder: WAIT_CYCLES must be within 0..15 (4-bit wait counter)");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int         DEPTH         = 2 ** ADDR_WIDTH;
  localparam logic       LP_ZERO_WAIT  = (WAIT_CYCLES == 0) ? 1'b1 : 1'b0;
  localparam logic [3:0] LP_COUNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
`ifdef WRITE_ACK_EN
  localparam logic       LP_WRITE_ACK  = 1'b1;
`else
  localparam logic       LP_WRITE_ACK  = 1'b0;
`endif

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [3:0]            r_count;
  logic [3:0]            w_count_nxt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_xfer;
  logic                  w_acc_en;
  logic                  w_acc_we;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic [31:0]           w_acc_wdata;

  assign w_xfer     = req_valid && (r_state == S_IDLE);
  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;

  // Access select: live request fields on a zero-wait transfer edge, captured fields on the last BUSY edge.
  always_comb begin
    w_acc_en    = 1'b0;
    w_acc_we    = r_we;
    w_acc_addr  = r_addr;
    w_acc_wdata = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_xfer && LP_ZERO_WAIT) begin
          w_acc_en    = 1'b1;
          w_acc_we    = req_we;
          w_acc_addr  = req_addr;
          w_acc_wdata = req_wdata;
        end else begin
          w_acc_en    = 1'b0;
        end
      end
      S_BUSY: begin
        if (r_count == 4'd0) begin
          w_acc_en = 1'b1;
        end else begin
          w_acc_en = 1'b0;
        end
      end
      default: begin
        w_acc_en = 1'b0;
      end
    endcase
  end

  // Next-state and wait counter; unacknowledged writes return straight to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (LP_ZERO_WAIT) begin
            w_state_nxt = (req_we && !LP_WRITE_ACK) ? S_IDLE : S_RESP;
          end else begin
            w_state_nxt = S_BUSY;
            w_count_nxt = LP_COUNT_INIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_count == 4'd0) begin
          w_state_nxt = (r_we && !LP_WRITE_ACK) ? S_IDLE : S_RESP;
        end else begin
          w_count_nxt = r_count - 4'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = 4'd0;
      end
    endcase
  end

  // Control state, request capture and read-data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_xfer) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end else begin
        r_we    <= r_we;
      end
      if (w_acc_en && !w_acc_we) begin
        r_rdata <= r_mem[w_acc_addr];
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  // Storage array is deliberately not reset; a write held off by reset never commits.
  always_ff @(posedge clk) begin
    if (w_acc_en && w_acc_we && !reset) begin
      r_mem[w_acc_addr] <= w_acc_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_CYCLES 0, 1, 3) exercised one at a time.
// Expectations follow WRITE_ACK_EN the same way the design does.
module tb_mem_responder;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    req_valid = 3'b000;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'd0;
  logic [2:0]    req_ready;
  logic [2:0]    resp_valid;
  logic [31:0]   resp_rdata [0:2];

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [31:0]   exp_q [$];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]));

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]));

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Present a request on instance d; returns #1 after the transfer edge (cycle t+1).
  task automatic xfer(input int d, input logic we, input logic [AW-1:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    req_we = we;
    req_addr = a;
    req_wdata = wd;
    req_valid[d[1:0]] = 1'b1;
    while (req_ready[d[1:0]] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check1($sformatf("xfer_ready_wait_d%0d", d), (n < 50), 1'b1);
    tick();
    req_valid[d[1:0]] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [AW-1:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    xfer(d, 1'b1, a, wd);
    while (req_ready[d[1:0]] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check1($sformatf("wr_idle_wait_d%0d", d), (n < 50), 1'b1);
  endtask

  // Called at cycle t+1; waits for the response and checks latency and scoreboard data.
  task automatic wait_resp(input int d, input int exp_lat, input string tag);
    int          c;
    logic [31:0] expv;
    c = 1;
    while (resp_valid[d[1:0]] !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    check32({tag, "_latency"}, 32'(c), 32'(exp_lat));
    check1({tag, "_ready_in_resp"}, req_ready[d[1:0]], 1'b0);
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
    end else begin
      expv = 32'hxxxxxxxx;
    end
    check32({tag, "_rdata"}, resp_rdata[d[1:0]], expv);
    tick();
    check1({tag, "_pulse_one_cycle"}, resp_valid[d[1:0]], 1'b0);
    check1({tag, "_ready_back"}, req_ready[d[1:0]], 1'b1);
  endtask

  task automatic rd(input int d, input logic [AW-1:0] a, input logic [31:0] expv, input int lat, input string tag);
    exp_q.push_back(expv);
    xfer(d, 1'b0, a, 32'd0);
    wait_resp(d, lat, tag);
  endtask

  // Write on the WAIT_CYCLES=1 instance, checking the ready/valid profile of both builds.
  task automatic wr_profile(input logic [AW-1:0] a, input logic [31:0] wd, input logic [31:0] prior, input string tag);
    xfer(1, 1'b1, a, wd);
    check1({tag, "_t1_ready"}, req_ready[1], 1'b0);
    check1({tag, "_t1_valid"}, resp_valid[1], 1'b0);
    tick();
`ifdef WRITE_ACK_EN
    check1({tag, "_t2_ack_valid"}, resp_valid[1], 1'b1);
    check1({tag, "_t2_ready"}, req_ready[1], 1'b0);
`else
    check1({tag, "_t2_no_ack_valid"}, resp_valid[1], 1'b0);
    check1({tag, "_t2_ready"}, req_ready[1], 1'b1);
`endif
    check32({tag, "_t2_rdata_kept"}, resp_rdata[1], prior);
    tick();
    check1({tag, "_t3_ready"}, req_ready[1], 1'b1);
    check1({tag, "_t3_valid"}, resp_valid[1], 1'b0);
  endtask

  initial begin
    // Asynchronous reset, mid-cycle, before any clock edge.
    #3;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check1($sformatf("rst_async_ready_d%0d", d), req_ready[d], 1'b1);
      check1($sformatf("rst_async_valid_d%0d", d), resp_valid[d], 1'b0);
      check32($sformatf("rst_async_rdata_d%0d", d), resp_rdata[d], 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        check1($sformatf("rst_hold%0d_ready_d%0d", k, d), req_ready[d], 1'b1);
        check1($sformatf("rst_hold%0d_valid_d%0d", k, d), resp_valid[d], 1'b0);
        check32($sformatf("rst_hold%0d_rdata_d%0d", k, d), resp_rdata[d], 32'd0);
      end
    end
    reset = 1'b0;
    tick();

    // WAIT_CYCLES=1: write then read back.
    wr_profile(10'd5, 32'hDEADBEEF, 32'd0, "w1_wr5");
    rd(1, 10'd5, 32'hDEADBEEF, 2, "w1_rd5");

    // WAIT_CYCLES=1: write acknowledge behaviour, rdata keeps the last read value.
    wr_profile(10'd3, 32'hA5A5A5A5, 32'hDEADBEEF, "w1_wr3");
    rd(1, 10'd3, 32'hA5A5A5A5, 2, "w1_rd3");

    // WAIT_CYCLES=0: back-to-back reads with req_valid held high.
    wr(0, 10'd0, 32'h00000011);
    wr(0, 10'd1, 32'h00000022);
    exp_q.push_back(32'h00000011);
    exp_q.push_back(32'h00000022);
    req_we = 1'b0;
    req_addr = 10'd0;
    req_valid[0] = 1'b1;
    check1("w0_b2b_ready_before", req_ready[0], 1'b1);
    tick();
    req_addr = 10'd1;
    check1("w0_b2b_r0_valid", resp_valid[0], 1'b1);
    check32("w0_b2b_r0_rdata", resp_rdata[0], exp_q.pop_front());
    check1("w0_b2b_r0_ready", req_ready[0], 1'b0);
    tick();
    check1("w0_b2b_gap_valid", resp_valid[0], 1'b0);
    check1("w0_b2b_gap_ready", req_ready[0], 1'b1);
    tick();
    req_valid[0] = 1'b0;
    check1("w0_b2b_r1_valid", resp_valid[0], 1'b1);
    check32("w0_b2b_r1_rdata", resp_rdata[0], exp_q.pop_front());
    tick();
    check1("w0_b2b_after_valid", resp_valid[0], 1'b0);
    check32("w0_b2b_rdata_holds", resp_rdata[0], 32'h00000022);

    // WAIT_CYCLES=3: read of the top address, request fields scrambled after transfer.
    wr(2, 10'd1023, 32'h0000CAFE);
    exp_q.push_back(32'h0000CAFE);
    xfer(2, 1'b0, 10'd1023, 32'd0);
    req_addr = 10'd9;
    req_wdata = 32'h5A5A0F0F;
    req_we = 1'b1;
    wait_resp(2, 4, "w3_rd1023");

    // WAIT_CYCLES=3: reset during the second BUSY cycle drops a pending write.
    wr(2, 10'd7, 32'h00000001);
    xfer(2, 1'b1, 10'd7, 32'h00000002);
    tick();
    #3;
    reset = 1'b1;
    #1;
    check1("w3_rst_busy_ready", req_ready[2], 1'b1);
    check1("w3_rst_busy_valid", resp_valid[2], 1'b0);
    check32("w3_rst_busy_rdata", resp_rdata[2], 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check1($sformatf("w3_rst_no_resp%0d", k), resp_valid[2], 1'b0);
      tick();
    end
    rd(2, 10'd7, 32'h00000001, 4, "w3_rd7_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
